// File: rtl/pipe_seq_pkg.sv
// Shared encodings for the ID/EX/WB pipeline sequencer: FSM states, panel opcodes and
// the stall-counter width helper.
package pipe_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MUL_WAIT = 2'd2,
      ST_BREAK    = 2'd3
   } seq_state_e;

   localparam logic [3:0] OP_JMP = 4'd11;
   localparam logic [3:0] OP_BEQ = 4'd12;
   localparam logic [3:0] OP_GHI = 4'd13;
   localparam logic [3:0] OP_GLO = 4'd14;

   // Width of a counter holding 0..lat, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned lat);
      int unsigned w;
      w = $clog2(lat + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_edge_det.sv
// Rising-edge detector for the debounced step key; the previous level is held in a register
// cleared by the asynchronous reset.
module seq_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   output logic edge_o
);

   logic req_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q <= 1'b0;
      end else begin
         req_q <= req_i;
      end
   end

   assign edge_o = req_i & ~req_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline-advance sequencer: free run, single step, multiply stalls and an optional PC
// breakpoint (present only when PIPE_BP_EN is defined). All outputs are registered.
module pipe_seq_ctrl
   import pipe_seq_pkg::*;
#(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned PC_W    = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            run_mode_i,
   input  logic            step_req_i,
   input  logic            ex_mul_i,
   input  logic [PC_W-1:0] pc_i,
   input  logic [PC_W-1:0] bp_addr_i,
   input  logic            bp_valid_i,
   output logic            pipe_en_o,
   output logic            mul_start_o,
   output logic            mul_busy_o,
   output logic            halted_o,
   output logic            bp_hit_o,
   output logic [1:0]      state_o,
   output logic [15:0]     retired_o
);

   localparam int unsigned     CNT_W    = cnt_width(MUL_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit              MUL_STALL = (MUL_LAT > 0);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             pipe_en_q, pipe_en_d;
   logic             mul_start_q, mul_start_d;
   logic             mul_busy_q, mul_busy_d;
   logic             halted_q, halted_d;
   logic             bp_hit_q, bp_hit_d;
   logic [15:0]      retired_q, retired_d;
   logic             step_edge;
   logic             bp_match;
   logic             adv;

   seq_edge_det u_step_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (step_req_i),
      .edge_o (step_edge)
   );

`ifdef PIPE_BP_EN
   assign bp_match = bp_valid_i && (pc_i == bp_addr_i);
`else
   logic unused_bp;
   assign unused_bp = ^{pc_i, bp_addr_i, bp_valid_i};
   assign bp_match  = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pipe_en_d   = 1'b0;
      mul_start_d = 1'b0;
      bp_hit_d    = bp_hit_q;
      adv         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (run_mode_i) begin
               state_d = ST_RUN;
            end else if (step_edge || pend_q) begin
               adv    = 1'b1;
               pend_d = 1'b0;
            end
         end
         ST_RUN: begin
            pend_d = 1'b0;
            if (!run_mode_i) begin
               state_d = ST_IDLE;
            end else if (bp_match) begin
               // Breakpoint wins over a multiply stall: nothing is issued.
               state_d  = ST_BREAK;
               bp_hit_d = 1'b1;
            end else begin
               adv = 1'b1;
            end
         end
         ST_MUL_WAIT: begin
            if (step_edge) begin
               pend_d = 1'b1;
            end
            if (cnt_q == CNT_ONE) begin
               pipe_en_d = 1'b1;
               state_d   = run_mode_i ? ST_RUN : ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_BREAK: begin
`ifdef PIPE_BP_EN
            // The step advance bypasses the compare, so the same PC can be left.
            if (step_edge) begin
               adv     = 1'b1;
               state_d = run_mode_i ? ST_RUN : ST_IDLE;
            end else if (!run_mode_i) begin
               state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
      endcase

      if (adv) begin
         if (ex_mul_i && MUL_STALL) begin
            mul_start_d = 1'b1;
            state_d     = ST_MUL_WAIT;
            cnt_d       = CNT_LOAD;
         end else begin
            pipe_en_d = 1'b1;
         end
      end

      if (pipe_en_d) begin
         bp_hit_d = 1'b0;
      end

      retired_d  = retired_q + 16'(pipe_en_d);
      mul_busy_d = (state_d == ST_MUL_WAIT);
      halted_d   = (state_d == ST_IDLE) || (state_d == ST_BREAK);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         pipe_en_q   <= 1'b0;
         mul_start_q <= 1'b0;
         mul_busy_q  <= 1'b0;
         halted_q    <= 1'b1;
         bp_hit_q    <= 1'b0;
         retired_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pipe_en_q   <= pipe_en_d;
         mul_start_q <= mul_start_d;
         mul_busy_q  <= mul_busy_d;
         halted_q    <= halted_d;
         bp_hit_q    <= bp_hit_d;
         retired_q   <= retired_d;
      end
   end

   assign pipe_en_o   = pipe_en_q;
   assign mul_start_o = mul_start_q;
   assign mul_busy_o  = mul_busy_q;
   assign halted_o    = halted_q;
   assign bp_hit_o    = bp_hit_q;
   assign state_o     = state_q;
   assign retired_o   = retired_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: directed stimulus queues expected pipe_en and
// mul_start cycles; a negedge monitor pops and compares them as the DUT produces them.
module tb_pipe_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        run_mode_i;
   logic        step_req_i;
   logic        ex_mul_i;
   logic [15:0] pc_i;
   logic [15:0] bp_addr_i;
   logic        bp_valid_i;
   logic        pipe_en_o;
   logic        mul_start_o;
   logic        mul_busy_o;
   logic        halted_o;
   logic        bp_hit_o;
   logic [1:0]  state_o;
   logic [15:0] retired_o;

   typedef struct {
      int          cyc;
      logic [15:0] ret;
   } en_t;

   en_t         en_q[$];
   int          ms_q[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          exp_ret = 0;
   logic [15:0] en_seen = 16'h0000;
   logic [15:0] pc_base = 16'h0000;

   // PC follows the number of advances the pipeline has accepted.
   assign pc_i = en_seen - pc_base;

   pipe_seq_ctrl #(
      .MUL_LAT (4),
      .PC_W    (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .run_mode_i  (run_mode_i),
      .step_req_i  (step_req_i),
      .ex_mul_i    (ex_mul_i),
      .pc_i        (pc_i),
      .bp_addr_i   (bp_addr_i),
      .bp_valid_i  (bp_valid_i),
      .pipe_en_o   (pipe_en_o),
      .mul_start_o (mul_start_o),
      .mul_busy_o  (mul_busy_o),
      .halted_o    (halted_o),
      .bp_hit_o    (bp_hit_o),
      .state_o     (state_o),
      .retired_o   (retired_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pipe_en_o === 1'b1) begin
         en_t e;
         en_seen = en_seen + 16'd1;
         total++;
         if (en_q.size() == 0) begin
            bad++;
            $display("FAIL pipe_en: unexpected pulse at cyc %0d (retired=%0d)", cyc, retired_o);
         end else begin
            e = en_q.pop_front();
            if (e.cyc != cyc || e.ret !== retired_o) begin
               bad++;
               $display("FAIL pipe_en: got cyc %0d retired %0d, want cyc %0d retired %0d",
                        cyc, retired_o, e.cyc, e.ret);
            end
         end
      end
      if (mul_start_o === 1'b1) begin
         total++;
         if (ms_q.size() == 0) begin
            bad++;
            $display("FAIL mul_start: unexpected pulse at cyc %0d", cyc);
         end else if (ms_q[0] != cyc) begin
            bad++;
            $display("FAIL mul_start: got cyc %0d, want cyc %0d", cyc, ms_q[0]);
            void'(ms_q.pop_front());
         end else begin
            void'(ms_q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic exp_en(input int c);
      en_t e;
      exp_ret++;
      e.cyc = c;
      e.ret = exp_ret[15:0];
      en_q.push_back(e);
   endtask

   task automatic exp_ms(input int c);
      ms_q.push_back(c);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " pipe_en"}, int'(pipe_en_o), 0);
      chk({tag, " mul_start"}, int'(mul_start_o), 0);
      chk({tag, " mul_busy"}, int'(mul_busy_o), 0);
      chk({tag, " halted"}, int'(halted_o), 1);
      chk({tag, " bp_hit"}, int'(bp_hit_o), 0);
      chk({tag, " state"}, int'(state_o), 0);
      chk({tag, " retired"}, int'(retired_o), 0);
   endtask

   initial begin
      int c;
      int d;
      rst_i      = 1'b1;
      run_mode_i = 1'b0;
      step_req_i = 1'b0;
      ex_mul_i   = 1'b0;
      bp_addr_i  = 16'h0000;
      bp_valid_i = 1'b0;
      tick(2);
      chk_reset("reset");
      rst_i = 1'b0;
      tick(2);

      // Single step: one advance per key edge, however long the key is held.
      c = cyc;
      step_req_i = 1'b1;
      exp_en(c + 1);
      tick(10);
      step_req_i = 1'b0;
      tick(2);
      chk("step retired", int'(retired_o), exp_ret);
      chk("step halted", int'(halted_o), 1);
      chk("step state", int'(state_o), 0);

      // Free run; run_mode beats a simultaneous step edge.
      c = cyc;
      run_mode_i = 1'b1;
      step_req_i = 1'b1;
      for (int i = 2; i <= 9; i++) exp_en(c + i);
      tick(3);
      chk("run state", int'(state_o), 1);
      chk("run halted", int'(halted_o), 0);
      tick(6);
      run_mode_i = 1'b0;
      step_req_i = 1'b0;
      tick(2);
      chk("run stop halted", int'(halted_o), 1);
      chk("run stop state", int'(state_o), 0);
      chk("run retired", int'(retired_o), exp_ret);

      // Multiply stall in free run.
      c = cyc;
      run_mode_i = 1'b1;
      ex_mul_i   = 1'b1;
      exp_ms(c + 2);
      exp_en(c + 6);
      exp_en(c + 7);
      tick(2);
      ex_mul_i = 1'b0;
      chk("mul busy first", int'(mul_busy_o), 1);
      chk("mul state", int'(state_o), 2);
      tick(3);
      chk("mul busy last", int'(mul_busy_o), 1);
      tick(1);
      chk("mul busy done", int'(mul_busy_o), 0);
      chk("mul back to run", int'(state_o), 1);
      tick(1);
      run_mode_i = 1'b0;
      tick(2);
      chk("mul state idle", int'(state_o), 0);
      chk("mul retired", int'(retired_o), exp_ret);

`ifdef PIPE_BP_EN
      c = cyc;
      pc_base    = en_seen;
      bp_addr_i  = 16'h0005;
      bp_valid_i = 1'b1;
      run_mode_i = 1'b1;
      for (int i = 2; i <= 6; i++) exp_en(c + i);
      tick(8);
      chk("bp state", int'(state_o), 3);
      chk("bp hit", int'(bp_hit_o), 1);
      chk("bp halted", int'(halted_o), 1);
      chk("bp pc", int'(pc_i), 5);
      d = cyc;
      step_req_i = 1'b1;
      exp_en(d + 1);
      exp_en(d + 2);
      tick(1);
      chk("bp hit cleared", int'(bp_hit_o), 0);
      chk("bp resume state", int'(state_o), 1);
      tick(1);
      run_mode_i = 1'b0;
      step_req_i = 1'b0;
      bp_valid_i = 1'b0;
      tick(2);
      chk("bp end state", int'(state_o), 0);
`else
      // Without the breakpoint feature an armed compare must not stop the run.
      c = cyc;
      pc_base    = en_seen;
      bp_addr_i  = 16'h0002;
      bp_valid_i = 1'b1;
      run_mode_i = 1'b1;
      for (int i = 2; i <= 6; i++) exp_en(c + i);
      tick(5);
      chk("nobp state", int'(state_o), 1);
      chk("nobp hit", int'(bp_hit_o), 0);
      tick(1);
      run_mode_i = 1'b0;
      bp_valid_i = 1'b0;
      tick(2);
      chk("nobp end state", int'(state_o), 0);
      chk("nobp pc", int'(pc_i), 5);
`endif

      // Step edges during a stall: the first is kept pending, the next is dropped.
      c = cyc;
      ex_mul_i   = 1'b1;
      step_req_i = 1'b1;
      exp_ms(c + 1);
      exp_en(c + 5);
      exp_en(c + 6);
      tick(1);
      step_req_i = 1'b0;
      tick(1);
      step_req_i = 1'b1;
      tick(1);
      step_req_i = 1'b0;
      ex_mul_i   = 1'b0;
      chk("pend state mulwait", int'(state_o), 2);
      tick(1);
      step_req_i = 1'b1;
      tick(1);
      step_req_i = 1'b0;
      chk("pend state idle", int'(state_o), 0);
      tick(4);
      chk("pend retired", int'(retired_o), exp_ret);

      // Reset in the middle of a stall abandons the multiply.
      c = cyc;
      run_mode_i = 1'b1;
      ex_mul_i   = 1'b1;
      exp_ms(c + 2);
      tick(3);
      chk("pre-reset busy", int'(mul_busy_o), 1);
      rst_i = 1'b1;
      #1;
      chk_reset("midrst");
      exp_ret    = 0;
      run_mode_i = 1'b0;
      ex_mul_i   = 1'b0;
      tick(1);
      rst_i = 1'b0;
      tick(8);
      chk("postrst retired", int'(retired_o), 0);
      chk("postrst state", int'(state_o), 0);
      chk("postrst busy", int'(mul_busy_o), 0);

      chk("pipe_en events left", en_q.size(), 0);
      chk("mul_start events left", ms_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
